qam_demap_pack: RTL and testbench

- Parametrised hard-decision QAM demapper with a byte packer.
- Slices complex symbols (ar, ai) into Gray-coded bits for QPSK, 16-QAM or 64-QAM, selected per frame.
- Packs the bits MSB-first into a byte stream with valid/ready backpressure and frame-end flush.
- Sits between the equaliser output and the descrambler/byte sink on the receive path.

---
 rtl/qam_demap_pkg.sv | 47 ++++
 rtl/qam_slice_axis.sv | 51 +++++
 rtl/qam_demap_pack.sv | 198 +++++++++++++++++++
 tb/tb_qam_demap_pack.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_demap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_demap_pkg
// Purpose  : Shared definitions for the QAM hard-decision demapper / packer:
//            constellation mode encodings, bits-per-symbol lookup, and the
//            widths of the packer accumulator and bit counter.
// Ports    : none (package)
// Config   : QAM_DEMAP_CLIP_CNT_EN is consumed by qam_demap_pack and
//            qam_slice_axis, not by this package.
// Revision : 1.0  initial release
// ============================================================================
package qam_demap_pkg;

  typedef enum logic [1:0] {
    MODE_QPSK = 2'd0,
    MODE_16   = 2'd1,
    MODE_64   = 2'd2,
    MODE_RSVD = 2'd3
  } qam_mode_e;

  // Largest symbol (64-QAM) carries six bits.
  localparam int MAX_BITS = 6;
  // Up to 7 leftover bits plus one 6-bit symbol.
  localparam int ACC_W    = 13;
  localparam int CNT_W    = 4;

  // Map the raw mode input onto a supported constellation; the reserved
  // code decodes as QPSK.
  function automatic qam_mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_16;
      2'd2:    return MODE_64;
      default: return MODE_QPSK;
    endcase
  endfunction

  // Bits produced per symbol for a (supported) mode.
  function automatic logic [2:0] nb_of(input qam_mode_e m);
    case (m)
      MODE_16: return 3'd4;
      MODE_64: return 3'd6;
      default: return 3'd2;
    endcase
  endfunction

endpackage : qam_demap_pkg
`default_nettype wire

// File: rtl/qam_slice_axis.sv
`default_nettype none
// ============================================================================
// Module   : qam_slice_axis
// Purpose  : Combinational hard-decision slicer for one axis (I or Q).
//            Produces the sign bit and the Gray-coded magnitude bits.
// Ports    : a_i     signed axis sample (DW bits)
//            is64_i  1 = 64-QAM thresholds, 0 = QPSK/16-QAM thresholds
//            s_o     a >= 0
//            m1_o    |a| >= THR (16-QAM) or |a| >= 2*THR (64-QAM)
//            m2_o    THR <= |a| < 3*THR (only meaningful for 64-QAM)
//            clip_o  |a| at/over outer limit (only with QAM_DEMAP_CLIP_CNT_EN)
// Config   : QAM_DEMAP_CLIP_CNT_EN adds the clip_o output.
// Revision : 1.0  initial release
// ============================================================================
module qam_slice_axis #(
  parameter int DW  = 11,
  parameter int THR = 4
) (
  input  logic [DW-1:0] a_i,
  input  logic          is64_i,
  output logic          s_o,
  output logic          m1_o,
  output logic          m2_o
`ifdef QAM_DEMAP_CLIP_CNT_EN
  ,
  output logic          clip_o
`endif
);

  localparam logic [DW:0] C_T1 = (DW+1)'(THR);
  localparam logic [DW:0] C_T2 = (DW+1)'(2*THR);
  localparam logic [DW:0] C_T3 = (DW+1)'(3*THR);

  logic [DW:0] ext;
  logic [DW:0] mag;

  // One extra bit so that |most negative| is representable.
  assign ext = {a_i[DW-1], a_i};
  assign mag = a_i[DW-1] ? (~ext + {{DW{1'b0}}, 1'b1}) : ext;

  assign s_o  = ~a_i[DW-1];
  assign m1_o = is64_i ? (mag >= C_T2) : (mag >= C_T1);
  assign m2_o = (mag >= C_T1) && (mag < C_T3);

`ifdef QAM_DEMAP_CLIP_CNT_EN
  localparam logic [DW:0] C_T4 = (DW+1)'(4*THR);
  assign clip_o = is64_i ? (mag >= C_T4) : (mag >= C_T2);
`endif

endmodule : qam_slice_axis
`default_nettype wire

// File: rtl/qam_demap_pack.sv
`default_nettype none
// ============================================================================
// Module   : qam_demap_pack
// Purpose  : Hard-decision QAM demapper (QPSK / 16-QAM / 64-QAM, chosen per
//            frame) followed by an MSB-first byte packer with valid/ready
//            flow control and end-of-frame flush.
// Ports    : CLK, RST          clock; asynchronous active-low reset
//            mode_i            0=QPSK 1=16QAM 2=64QAM 3=QPSK, latched on the
//                              first symbol of each frame
//            valid_i/ready_o   symbol handshake; last_i ends a frame
//            ar, ai            signed I/Q samples (DW bits)
//            valid_o/ready_i   byte handshake
//            byte_o, last_o    packed byte (first bit in bit 7), frame end
//            clip_cnt_o        saturating clip counter (optional)
// Config   : define QAM_DEMAP_CLIP_CNT_EN to build the clip counter; when
//            undefined clip_cnt_o is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module qam_demap_pack
  import qam_demap_pkg::*;
#(
  parameter int DW  = 11,
  parameter int THR = 4,
  parameter int CW  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    mode_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          last_i,
  input  logic [DW-1:0] ar,
  input  logic [DW-1:0] ai,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [7:0]    byte_o,
  output logic          last_o,
  output logic [CW-1:0] clip_cnt_o
);

  // ---------------------------------------------------------------- mode
  qam_mode_e mode_q;
  logic      first_q;   // next accepted symbol opens a new frame
  qam_mode_e mode_eff;
  logic      accept;

  assign mode_eff = first_q ? to_mode(mode_i) : mode_q;
  assign accept   = valid_i && ready_o;

  // ---------------------------------------------------------------- slicers
  logic sI, sQ, m1I, m1Q, m2I, m2Q;
  logic is64;

  assign is64 = (mode_eff == MODE_64);

`ifdef QAM_DEMAP_CLIP_CNT_EN
  logic clipI, clipQ;
`endif

  qam_slice_axis #(.DW(DW), .THR(THR)) u_slice_i (
    .a_i    (ar),
    .is64_i (is64),
    .s_o    (sI),
    .m1_o   (m1I),
    .m2_o   (m2I)
`ifdef QAM_DEMAP_CLIP_CNT_EN
    ,
    .clip_o (clipI)
`endif
  );

  qam_slice_axis #(.DW(DW), .THR(THR)) u_slice_q (
    .a_i    (ai),
    .is64_i (is64),
    .s_o    (sQ),
    .m1_o   (m1Q),
    .m2_o   (m2Q)
`ifdef QAM_DEMAP_CLIP_CNT_EN
    ,
    .clip_o (clipQ)
`endif
  );

  // Symbol bits left-aligned in MAX_BITS, first decided bit at the top.
  logic [MAX_BITS-1:0] sym_bits;

  always_comb begin
    sym_bits = '0;
    case (mode_eff)
      MODE_16: sym_bits = {sI, sQ, m1I, m1Q, 2'b00};
      MODE_64: sym_bits = {sI, sQ, m1I, m1Q, m2I, m2Q};
      default: sym_bits = {sI, sQ, 4'b0000};
    endcase
  end

  // ---------------------------------------------------------------- stage 1
  logic                s1_valid_q;
  logic [MAX_BITS-1:0] s1_bits_q;
  logic [2:0]          s1_nb_q;
  logic                s1_last_q;
  logic                append;

  assign ready_o = !s1_valid_q || append;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_bits_q  <= '0;
      s1_nb_q    <= 3'd0;
      s1_last_q  <= 1'b0;
      mode_q     <= MODE_QPSK;
      first_q    <= 1'b1;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_bits_q  <= sym_bits;
        s1_nb_q    <= nb_of(mode_eff);
        s1_last_q  <= last_i;
        mode_q     <= mode_eff;
        first_q    <= last_i;
      end else if (append) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Accumulator is MSB-aligned: valid bits occupy acc_q[ACC_W-1 -: cnt_q],
  // everything below is kept zero so a flush byte is padded for free.
  logic [ACC_W-1:0] acc_q, acc_d, acc_pop, ins;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_pop;
  logic             lp_q, lp_d, lp_pop;   // frame's last symbol is in acc
  logic             out_valid, out_last, pop;

  assign out_valid = (cnt_q >= 4'd8) || (lp_q && (cnt_q != 4'd0));
  // With the final symbol buffered, the byte is the last one once no more
  // than eight bits remain (exactly 8 = full final byte, <8 = padded).
  assign out_last  = lp_q && (cnt_q != 4'd0) && (cnt_q <= 4'd8);
  assign pop       = out_valid && ready_i;
  assign ins       = {s1_bits_q, {(ACC_W-MAX_BITS){1'b0}}};

  always_comb begin
    acc_pop = acc_q;
    cnt_pop = cnt_q;
    lp_pop  = lp_q;
    if (pop) begin
      acc_pop = acc_q << 8;
      cnt_pop = (cnt_q >= 4'd8) ? (cnt_q - 4'd8) : 4'd0;
      if (out_last) lp_pop = 1'b0;
    end
    // Appending is judged on the post-pop state so a byte leaving and a
    // symbol entering can share a cycle (full rate even for 64-QAM).
    append = s1_valid_q && (cnt_pop < 4'd8) && !lp_pop;
    acc_d  = acc_pop;
    cnt_d  = cnt_pop;
    lp_d   = lp_pop;
    if (append) begin
      acc_d = acc_pop | (ins >> cnt_pop);
      cnt_d = cnt_pop + {1'b0, s1_nb_q};
      lp_d  = s1_last_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
      cnt_q <= '0;
      lp_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      lp_q  <= lp_d;
    end
  end

  assign valid_o = out_valid;
  assign last_o  = out_last;
  assign byte_o  = acc_q[ACC_W-1 -: 8];

  // ---------------------------------------------------------------- clip
`ifdef QAM_DEMAP_CLIP_CNT_EN
  logic [CW-1:0] clip_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clip_q <= '0;
    end else if (accept && (clipI || clipQ) && (clip_q != {CW{1'b1}})) begin
      clip_q <= clip_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign clip_cnt_o = clip_q;
`else
  assign clip_cnt_o = '0;
`endif

endmodule : qam_demap_pack
`default_nettype wire

// File: tb/tb_qam_demap_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_demap_pack
// Purpose  : Directed self-checking bench for qam_demap_pack (THR=4, DW=11).
// Config   : honours QAM_DEMAP_CLIP_CNT_EN for the clip counter expectation.
// Revision : 1.0  initial release
// ============================================================================
module tb_qam_demap_pack;

  localparam int DW  = 11;
  localparam int THR = 4;
  localparam int CW  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          last_i = 1'b0;
  logic [DW-1:0] ar = '0;
  logic [DW-1:0] ai = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [7:0]    byte_o;
  logic          last_o;
  logic [CW-1:0] clip_cnt_o;

  qam_demap_pack #(.DW(DW), .THR(THR), .CW(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mode_i     (mode_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .last_i     (last_i),
    .ar         (ar),
    .ai         (ai),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .byte_o     (byte_o),
    .last_o     (last_o),
    .clip_cnt_o (clip_cnt_o)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // {last, byte}
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  int f_ar[$];
  int f_ai[$];
  int f_md[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Byte monitor: handshake values are stable at the falling edge.
  always @(negedge CLK) begin
    if (RST && valid_o && ready_i) rx_q.push_back({last_o, byte_o});
  end

  // Reference slicer/packer
  function automatic int nbits(input int mode);
    if (mode == 1) return 4;
    if (mode == 2) return 6;
    return 2;
  endfunction

  function automatic logic [5:0] ref_bits(input int mode, input int xr, input int xi);
    int   ar_m, ai_m, t1;
    logic sI, sQ, m1I, m1Q, m2I, m2Q;
    ar_m = (xr < 0) ? -xr : xr;
    ai_m = (xi < 0) ? -xi : xi;
    t1   = (mode == 2) ? 2*THR : THR;
    sI   = (xr >= 0);
    sQ   = (xi >= 0);
    m1I  = (ar_m >= t1);
    m1Q  = (ai_m >= t1);
    m2I  = (ar_m >= THR) && (ar_m < 3*THR);
    m2Q  = (ai_m >= THR) && (ai_m < 3*THR);
    if (mode == 1) return {sI, sQ, m1I, m1Q, 2'b00};
    if (mode == 2) return {sI, sQ, m1I, m1Q, m2I, m2Q};
    return {sI, sQ, 4'b0000};
  endfunction

  task automatic model_frame(input int mode);
    logic       bq[$];
    logic [5:0] b;
    logic [7:0] by;
    exp_q.delete();
    for (int i = 0; i < f_ar.size(); i++) begin
      b = ref_bits(mode, f_ar[i], f_ai[i]);
      for (int j = 0; j < nbits(mode); j++) bq.push_back(b[5-j]);
    end
    while (bq.size() > 0) begin
      by = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (bq.size() > 0) by[7-j] = bq.pop_front();
      end
      exp_q.push_back({(bq.size() == 0), by});
    end
  endtask

  // Drive one symbol from posedge+1 until accepted.
  task automatic send_sym(input int md, input int xr, input int xi, input logic lst);
    int t;
    mode_i  = md[1:0];
    ar      = xr[DW-1:0];
    ai      = xi[DW-1:0];
    last_i  = lst;
    valid_i = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!ready_o && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < f_ar.size(); i++)
      send_sym(f_md[i], f_ar[i], f_ai[i], (i == f_ar.size() - 1));
  endtask

  task automatic collect_compare(input string tag);
    int t;
    t = 0;
    while (rx_q.size() < exp_q.size() && t < 300) begin
      @(posedge CLK);
      t++;
    end
    repeat (6) @(posedge CLK);
    #1;
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {23'd0, rx_q[i]}, {23'd0, exp_q[i]});
    rx_q.delete();
  endtask

  task automatic set_frame(input int md, input int xr[], input int xi[]);
    f_ar.delete(); f_ai.delete(); f_md.delete();
    for (int i = 0; i < xr.size(); i++) begin
      f_ar.push_back(xr[i]);
      f_ai.push_back(xi[i]);
      f_md.push_back(md);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  logic [7:0] held;

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_last_o",  last_o,  0);
    chk("rst_byte_o",  byte_o,  0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_clip",    clip_cnt_o, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // ---------------- 1: 16QAM Gray slicing -> 0011 0000, 1100 1111
    set_frame(1, '{-6, -2, 2, 6}, '{-6, -2, 2, 6});
    exp_q.delete();
    exp_q.push_back(9'h030);
    exp_q.push_back(9'h1CF);
    send_frame();
    collect_compare("t1_16qam");

    // ---------------- 2: 64QAM |10| -> 111111 x4 = three 0xFF bytes
    set_frame(2, '{10, 10, 10, 10}, '{10, 10, 10, 10});
    exp_q.delete();
    exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h1FF);
    send_frame();
    collect_compare("t2_64qam");

    // ---------------- 3: QPSK (1,-1) x3 -> 10 10 10 + 00 pad = 0xA8
    set_frame(0, '{1, 1, 1}, '{-1, -1, -1});
    exp_q.delete();
    exp_q.push_back(9'h1A8);
    send_frame();
    collect_compare("t3_qpsk");

    // ---------------- 4: backpressure, 16QAM, 8 symbols
    set_frame(1, '{-7, 5, 0, -3, 2, -9, 4, 1}, '{3, -1, -4, 8, 2, -2, -5, 6});
    model_frame(1);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send_sym(1, f_ar[i], f_ai[i], 1'b0);
    chk("t4_ready_low", ready_o, 0);
    chk("t4_valid_hi",  valid_o, 1);
    held = byte_o;
    chk("t4_first_byte", held, exp_q[0][7:0]);
    repeat (20) @(posedge CLK);
    #1;
    chk("t4_byte_held",   byte_o,  held);
    chk("t4_still_stall", ready_o, 0);
    ready_i = 1'b1;
    for (int i = 3; i < 8; i++) send_sym(1, f_ar[i], f_ai[i], (i == 7));
    collect_compare("t4_bp");

    // ---------------- 5: mode_i toggles mid-frame; 64QAM kept
    set_frame(2, '{13, -5, 3, -12, 20}, '{-13, 7, -9, 0, -1});
    f_md[1] = 1; f_md[2] = 0; f_md[3] = 3; f_md[4] = 1;
    model_frame(2);
    send_frame();
    collect_compare("t5_modelatch");

    // ---------------- 6: clip count, then reset mid-frame
    do_reset();
    set_frame(1, '{9, 9, 9, 9, 9}, '{0, 0, 0, 0, 0});
    for (int i = 0; i < 5; i++) send_sym(1, 9, 0, 1'b0);
    exp_q.delete();
    exp_q.push_back(9'h0EE);
    exp_q.push_back(9'h0EE);
    collect_compare("t6_pre");
`ifdef QAM_DEMAP_CLIP_CNT_EN
    chk("t6_clip_cnt", clip_cnt_o, 5);
`else
    chk("t6_clip_cnt", clip_cnt_o, 0);
`endif
    RST = 1'b0;
    #1;
    chk("t6_rst_valid_o", valid_o, 0);
    chk("t6_rst_last_o",  last_o,  0);
    chk("t6_rst_byte_o",  byte_o,  0);
    chk("t6_rst_ready_o", ready_o, 1);
    chk("t6_rst_clip",    clip_cnt_o, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("t6_no_stray", rx_q.size(), 0);
    rx_q.delete();
    set_frame(1, '{6}, '{6});
    exp_q.delete();
    exp_q.push_back(9'h1F0);
    send_frame();
    collect_compare("t6_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_qam_demap_pack
`default_nettype wire
